// File: rtl/mult_add_lanes.sv
// Multi-lane signed fixed-point MAC: per-beat lane products are summed and accumulated until a last beat.
// Optional clamping of the result to OUT_W bits is enabled by defining MAC_SAT_EN.
module mult_add_lanes #(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4,
  parameter int ACC_W    = 2*BITWIDTH+$clog2(LANES)+8,
  parameter int OUT_W    = 2*BITWIDTH,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_a,
  input  logic [LANES*BITWIDTH-1:0] in_b,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_sat
);

  localparam int PROD_W = 2*BITWIDTH;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {sat, data}: either a clamp into the signed OUT_W range or a plain truncation.
  function automatic logic [OUT_W:0] result_f(input logic [ACC_W-1:0] x);
`ifdef MAC_SAT_EN
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    min_v = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if ($signed(x) > max_v) begin
      result_f = {1'b1, max_v[OUT_W-1:0]};
    end else if ($signed(x) < min_v) begin
      result_f = {1'b1, min_v[OUT_W-1:0]};
    end else begin
      result_f = {1'b0, x[OUT_W-1:0]};
    end
`else
    result_f = {1'b0, x[OUT_W-1:0]};
`endif
  endfunction

  logic                      en_s;
  logic                      accept_s;
  logic                      v0_r;
  logic                      last0_r;
  logic [LANES*BITWIDTH-1:0] a0_r;
  logic [LANES*BITWIDTH-1:0] b0_r;
  logic                      v1_r;
  logic                      last1_r;
  logic [LANES*PROD_W-1:0]   prod_s;
  logic [LANES*PROD_W-1:0]   prod_r;
  logic [ACC_W-1:0]          sum_s;
  logic [ACC_W-1:0]          acc_r;
  logic [ACC_W-1:0]          acc_next_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [CNT_W-1:0]          cnt_next_s;
  logic                      first_r;
  logic [OUT_W:0]            res_s;
  logic                      out_valid_r;
  logic [OUT_W-1:0]          out_data_r;
  logic [CNT_W-1:0]          out_count_r;
  logic                      out_sat_r;

  // A held result blocks every stage, so the whole pipe advances on one enable.
  assign en_s      = !out_valid_r || out_ready;
  assign in_ready  = en_s && reset;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;
  assign out_sat   = out_sat_r;

  // Lane products, operands sign-extended so the low PROD_W bits are the signed product.
  always_comb begin
    logic [PROD_W-1:0] ax;
    logic [PROD_W-1:0] bx;
    prod_s = '0;
    for (int k = 0; k < LANES; k++) begin
      ax = {{BITWIDTH{a0_r[k*BITWIDTH+BITWIDTH-1]}}, a0_r[k*BITWIDTH +: BITWIDTH]};
      bx = {{BITWIDTH{b0_r[k*BITWIDTH+BITWIDTH-1]}}, b0_r[k*BITWIDTH +: BITWIDTH]};
      prod_s[k*PROD_W +: PROD_W] = ax * bx;
    end
  end

  // Adder tree over the registered products plus the accumulate/count update.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_s = sum_s + {{(ACC_W-PROD_W){prod_r[k*PROD_W+PROD_W-1]}}, prod_r[k*PROD_W +: PROD_W]};
    end
    if (first_r) begin
      acc_next_s = sum_s;
      cnt_next_s = CNT_ONE;
    end else begin
      acc_next_s = acc_r + sum_s;
      cnt_next_s = cnt_r + CNT_ONE;
    end
    res_s = result_f(acc_next_s);
  end

  // Input capture stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_r    <= 1'b0;
      last0_r <= 1'b0;
      a0_r    <= '0;
      b0_r    <= '0;
    end else if (en_s) begin
      v0_r <= accept_s;
      if (accept_s) begin
        last0_r <= in_last;
        a0_r    <= in_a;
        b0_r    <= in_b;
      end
    end
  end

  // Product register stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      prod_r  <= '0;
    end else if (en_s) begin
      v1_r <= v0_r;
      if (v0_r) begin
        last1_r <= last0_r;
        prod_r  <= prod_s;
      end
    end
  end

  // Accumulate stage and the result register held for the output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      first_r     <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_count_r <= '0;
      out_sat_r   <= 1'b0;
    end else if (en_s) begin
      if (v1_r) begin
        acc_r   <= acc_next_s;
        cnt_r   <= cnt_next_s;
        first_r <= last1_r;
      end
      if (v1_r && last1_r) begin
        out_valid_r <= 1'b1;
        out_data_r  <= res_s[OUT_W-1:0];
        out_count_r <= cnt_next_s;
        out_sat_r   <= res_s[OUT_W];
      end else if (out_ready && out_valid_r) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
